// File: rtl/add8_error_monitor.sv
// add8_error_monitor
// Collects error statistics for an 8-bit approximate adder over a programmed
// number of samples: sample count, error count (EP), worst-case error (WCE),
// and sums of |error| (MAE), error^2 (MSE) and Hamming distance (HD).
// Two-stage pipeline: stage 1 measures one sample, stage 2 accumulates it.
module add8_error_monitor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [CNT_W-1:0]              num_samples,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_a,
   input  logic [WIDTH-1:0]              in_b,
   input  logic [WIDTH:0]                in_o,
   output logic                          busy,
   output logic                          done,
   output logic [CNT_W-1:0]              sample_cnt,
   output logic [CNT_W-1:0]              err_cnt,
   output logic [WIDTH:0]                wce,
   output logic [WIDTH+CNT_W:0]          sae,
   output logic [2*(WIDTH+1)+CNT_W-1:0]  sse,
   output logic [CNT_W+3:0]              shd
);

   localparam int ED_W  = WIDTH + 1;
   localparam int SQ_W  = 2 * ED_W;
   localparam int HD_W  = $clog2(ED_W + 1);
   localparam int SAE_W = ED_W + CNT_W;
   localparam int SSE_W = SQ_W + CNT_W;
   localparam int SHD_W = CNT_W + 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  target;
   logic [CNT_W-1:0]  accepted;
   logic [CNT_W-1:0]  accepted_inc;
   logic              accept;
   logic              start_ok;

   // Stage 1 combinational measurement of the incoming sample
   logic [ED_W-1:0]   exact;
   logic [ED_W-1:0]   ed_c;
   logic [HD_W-1:0]   hd_c;

   // Stage 1 registers
   logic              s1_valid;
   logic [ED_W-1:0]   s1_ed;
   logic [HD_W-1:0]   s1_hd;
   logic              s1_nz;

   // Stage 2 combinational terms
   logic [SQ_W-1:0]   sq;
   logic [ED_W-1:0]   wce_next;

   function automatic logic [HD_W-1:0] popcount(input logic [ED_W-1:0] v);
      logic [HD_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < ED_W; i++) begin
         n = n + HD_W'(v[i]);
      end
      return n;
   endfunction

   // Handshake: accept only while a run still needs samples
   always_comb begin
      in_ready     = (state == RUN) && (accepted < target);
      accept       = in_valid && in_ready;
      start_ok     = start && ((state == IDLE) || (state == DONE));
      accepted_inc = accepted + CNT_W'(1);
   end

   // Exact sum, absolute error distance and bit-flip count of the sample
   always_comb begin
      exact = {1'b0, in_a} + {1'b0, in_b};
      if (in_o >= exact) begin
         ed_c = in_o - exact;
      end else begin
         ed_c = exact - in_o;
      end
      hd_c = popcount(in_o ^ exact);
   end

   // Squared error and running maximum for the accumulate stage
   always_comb begin
      sq = {{ED_W{1'b0}}, s1_ed} * {{ED_W{1'b0}}, s1_ed};
      if (s1_ed > wce) begin
         wce_next = s1_ed;
      end else begin
         wce_next = wce;
      end
   end

   // Run control FSM with registered busy/done.
   // DRAIN lasts exactly one cycle: no accepts happen there, so the last
   // sample retires from stage 1 into the accumulators on the same edge that
   // moves to DONE, which puts done two cycles after the final accept.
   // A zero-length run enters DONE directly and raises done one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         target   <= '0;
         accepted <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  target   <= num_samples;
                  accepted <= '0;
                  done     <= 1'b0;
                  if (num_samples != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  accepted <= accepted_inc;
                  if (accepted_inc == target) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            DONE: begin
               if (start_ok) begin
                  target   <= num_samples;
                  accepted <= '0;
                  done     <= 1'b0;
                  if (num_samples != '0) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                  end
               end else begin
                  done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Stage 1: capture per-sample error figures on accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_ed    <= '0;
         s1_hd    <= '0;
         s1_nz    <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_ed <= ed_c;
            s1_hd <= hd_c;
            s1_nz <= (ed_c != '0);
         end
      end
   end

   // Stage 2: accumulate statistics; a new run clears them
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_cnt <= '0;
         err_cnt    <= '0;
         wce        <= '0;
         sae        <= '0;
         sse        <= '0;
         shd        <= '0;
      end else if (start_ok) begin
         sample_cnt <= '0;
         err_cnt    <= '0;
         wce        <= '0;
         sae        <= '0;
         sse        <= '0;
         shd        <= '0;
      end else if (s1_valid) begin
         sample_cnt <= sample_cnt + CNT_W'(1);
         err_cnt    <= err_cnt + CNT_W'(s1_nz);
         wce        <= wce_next;
         sae        <= sae + SAE_W'(s1_ed);
         sse        <= sse + SSE_W'(sq);
         shd        <= shd + SHD_W'(s1_hd);
      end
   end

endmodule

// File: tb/tb_add8_error_monitor.sv
// Testbench for add8_error_monitor: table-driven runs with constant expected
// totals, a per-sample scoreboard of running totals due two cycles after each
// accept, and hand-written sequences for zero-length runs, ignored start
// pulses and mid-run reset.
module tb_add8_error_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] num_samples;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [8:0]  in_o;
   logic        busy;
   logic        done;
   logic [15:0] sample_cnt;
   logic [15:0] err_cnt;
   logic [8:0]  wce;
   logic [24:0] sae;
   logic [33:0] sse;
   logic [19:0] shd;

   add8_error_monitor #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_o(in_o), .busy(busy), .done(done), .sample_cnt(sample_cnt),
      .err_cnt(err_cnt), .wce(wce), .sae(sae), .sse(sse), .shd(shd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [8:0] o;
   } samp_t;

   typedef struct {
      string  name;
      int     first;
      int     count;
      bit     gap;
      longint cnt, err, wce, sae, sse, shd;
   } run_t;

   typedef struct {
      int     due;
      longint cnt, err, wce, sae, sse, shd;
   } snap_t;

   samp_t  smp[21];
   run_t   runs[4];
   snap_t  sb[$];

   int     n_tests = 0;
   int     n_fail  = 0;
   int     cycle   = 0;
   longint m_cnt, m_err, m_wce, m_sae, m_sse, m_shd;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_err = 0; m_wce = 0; m_sae = 0; m_sse = 0; m_shd = 0;
   endtask

   // One clock; model and queue any accept, then retire due scoreboard entries
   task automatic tick();
      bit         acc;
      int         ex;
      int         ed;
      logic [8:0] x;
      snap_t      s;
      acc = in_valid && in_ready;
      ex  = int'(in_a) + int'(in_b);
      ed  = int'(in_o) - ex;
      if (ed < 0) ed = -ed;
      x   = 9'(ex) ^ in_o;
      @(posedge clk);
      #1;
      cycle++;
      if (acc) begin
         m_cnt++;
         if (ed != 0) m_err++;
         if (ed > m_wce) m_wce = ed;
         m_sae += ed;
         m_sse += longint'(ed) * longint'(ed);
         m_shd += $countones(x);
         sb.push_back('{due: cycle + 1, cnt: m_cnt, err: m_err, wce: m_wce,
                        sae: m_sae, sse: m_sse, shd: m_shd});
      end
      while (sb.size() > 0 && sb[0].due == cycle) begin
         s = sb.pop_front();
         chk("sb sample_cnt", longint'(sample_cnt), s.cnt);
         chk("sb err_cnt",    longint'(err_cnt),    s.err);
         chk("sb wce",        longint'(wce),        s.wce);
         chk("sb sae",        longint'(sae),        s.sae);
         chk("sb sse",        longint'(sse),        s.sse);
         chk("sb shd",        longint'(shd),        s.shd);
      end
   endtask

   task automatic chk_results(input string tag, input longint c, input longint e,
                              input longint w, input longint a, input longint q,
                              input longint h);
      chk({tag, " sample_cnt"}, longint'(sample_cnt), c);
      chk({tag, " err_cnt"},    longint'(err_cnt),    e);
      chk({tag, " wce"},        longint'(wce),        w);
      chk({tag, " sae"},        longint'(sae),        a);
      chk({tag, " sse"},        longint'(sse),        q);
      chk({tag, " shd"},        longint'(shd),        h);
   endtask

   task automatic start_run(input int n);
      model_reset();
      start       = 1'b1;
      num_samples = 16'(n);
      tick();
      start       = 1'b0;
      chk("start busy", longint'(busy), (n != 0) ? 1 : 0);
      chk("start done", longint'(done), 0);
      chk("start in_ready", longint'(in_ready), (n != 0) ? 1 : 0);
      chk_results("start cleared", 0, 0, 0, 0, 0, 0);
   endtask

   task automatic feed(input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] o, input bit gap);
      bit got;
      if (gap) begin
         in_valid = 1'b0;
         in_a     = 8'($urandom);
         in_b     = 8'($urandom);
         in_o     = 9'($urandom);
         tick();
      end
      in_a     = a;
      in_b     = b;
      in_o     = o;
      in_valid = 1'b1;
      got      = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         got = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (!got) chk("accept timeout", longint'(in_ready), 1);
   endtask

   // Called right after the final accept's clock edge
   task automatic end_checks(input string tag, input longint c, input longint e,
                             input longint w, input longint a, input longint q,
                             input longint h);
      chk({tag, " ready drop"}, longint'(in_ready), 0);
      chk({tag, " busy drain"}, longint'(busy), 1);
      chk({tag, " done early"}, longint'(done), 0);
      tick();
      chk({tag, " done rise"}, longint'(done), 1);
      chk({tag, " busy end"},  longint'(busy), 0);
      chk_results(tag, c, e, w, a, q, h);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_a = 8'($urandom);
         in_o = 9'($urandom);
         tick();
      end
      in_valid = 1'b0;
      chk({tag, " hold cnt"},  longint'(sample_cnt), c);
      chk({tag, " hold done"}, longint'(done), 1);
   endtask

   task automatic feed_random(input int n);
      for (int i = 0; i < n; i++) begin
         feed(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              9'($urandom_range(0, 511)), 1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; num_samples = '0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_o = '0;
      model_reset();

      for (int i = 0; i < 16; i++) begin
         smp[i].a = 8'(i * 17);
         smp[i].b = 8'(255 - i * 9);
         smp[i].o = 9'(i * 17) + 9'(255 - i * 9);
      end
      smp[16] = '{a: 8'd0,   b: 8'd0,   o: 9'd1};
      smp[17] = '{a: 8'd255, b: 8'd255, o: 9'd0};
      smp[18] = '{a: 8'd3,   b: 8'd4,   o: 9'd7};
      smp[19] = '{a: 8'd10,  b: 8'd5,   o: 9'd12};
      smp[20] = '{a: 8'd1,   b: 8'd1,   o: 9'd9};

      // (10,5)->15 vs 12: ed 3, hd 2; (1,1)->2 vs 9: ed 7, hd 3
      runs[0] = '{name: "exact",   first: 0,  count: 16, gap: 1'b0,
                  cnt: 16, err: 0, wce: 0,   sae: 0,   sse: 0,      shd: 0};
      runs[1] = '{name: "single",  first: 16, count: 1,  gap: 1'b0,
                  cnt: 1,  err: 1, wce: 1,   sae: 1,   sse: 1,      shd: 1};
      runs[2] = '{name: "extreme", first: 17, count: 1,  gap: 1'b0,
                  cnt: 1,  err: 1, wce: 510, sae: 510, sse: 260100, shd: 8};
      runs[3] = '{name: "mixed",   first: 18, count: 3,  gap: 1'b1,
                  cnt: 3,  err: 2, wce: 7,   sae: 10,  sse: 58,     shd: 5};

      tick();
      tick();
      chk("reset busy",     longint'(busy), 0);
      chk("reset done",     longint'(done), 0);
      chk("reset in_ready", longint'(in_ready), 0);
      chk_results("reset", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();

      for (int r = 0; r < 4; r++) begin
         start_run(runs[r].count);
         for (int i = 0; i < runs[r].count; i++) begin
            feed(smp[runs[r].first + i].a, smp[runs[r].first + i].b,
                 smp[runs[r].first + i].o, runs[r].gap);
         end
         end_checks(runs[r].name, runs[r].cnt, runs[r].err, runs[r].wce,
                    runs[r].sae, runs[r].sse, runs[r].shd);
      end

      // Zero-length run
      start_run(0);
      tick();
      chk("zero done", longint'(done), 1);
      chk("zero in_ready", longint'(in_ready), 0);
      chk_results("zero", 0, 0, 0, 0, 0, 0);

      // Start pulse during RUN must be ignored
      start_run(4);
      feed_random(2);
      start       = 1'b1;
      num_samples = 16'd1;
      tick();
      start       = 1'b0;
      chk("ignored start busy", longint'(busy), 1);
      chk("ignored start cnt",  longint'(sample_cnt), 2);
      feed_random(2);
      end_checks("ignored start", m_cnt, m_err, m_wce, m_sae, m_sse, m_shd);
      chk("ignored start total", m_cnt, 4);

      // Reset in the middle of a run, then a clean run
      start_run(8);
      feed_random(5);
      sb.delete();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst busy",     longint'(busy), 0);
      chk("midrst done",     longint'(done), 0);
      chk("midrst in_ready", longint'(in_ready), 0);
      chk_results("midrst", 0, 0, 0, 0, 0, 0);
      tick();
      chk("midrst idle ready", longint'(in_ready), 0);
      start_run(3);
      feed_random(3);
      end_checks("post reset", m_cnt, m_err, m_wce, m_sae, m_sse, m_shd);
      chk("post reset total", m_cnt, 3);

      chk("scoreboard drained", longint'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
